// File: rtl/decode_inst_queue_pkg.sv
// Shared types for the decode instruction queue: fetch entry layout, issue width,
// fetch exception cause codes and a 2-bit population count helper.
package decode_inst_queue_pkg;

    localparam int ISSUE_WIDTH = 2;

    localparam logic [6:0] EXCEPTION_NONE        = 7'd0;
    localparam logic [6:0] EXCEPTION_INST_MISAL  = 7'd1;
    localparam logic [6:0] EXCEPTION_INST_FAULT  = 7'd2;
    localparam logic [6:0] EXCEPTION_INST_PAGE   = 7'd12;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        exc;
        logic [6:0]  exc_cause;
    } fetch_entry_t;

    function automatic logic [1:0] popcnt2(input logic [1:0] v);
        return {v[1] & v[0], v[1] ^ v[0]};
    endfunction

endpackage

// File: rtl/decode_inst_queue_iq_storage.sv
// Reset-free DEPTH-entry storage with two write ports and two asynchronous read
// ports; the two write addresses are always distinct.
module iq_storage
    import decode_inst_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic [1:0]                 we_i,
    input  logic [$clog2(DEPTH)-1:0]   waddr0_i,
    input  logic [$clog2(DEPTH)-1:0]   waddr1_i,
    input  fetch_entry_t               wdata0_i,
    input  fetch_entry_t               wdata1_i,
    input  logic [$clog2(DEPTH)-1:0]   raddr0_i,
    input  logic [$clog2(DEPTH)-1:0]   raddr1_i,
    output fetch_entry_t               rdata0_o,
    output fetch_entry_t               rdata1_o
);

    fetch_entry_t mem_q [DEPTH];

    // write ports
    always_ff @(posedge clk) begin
        if (we_i[0]) begin
            mem_q[waddr0_i] <= wdata0_i;
        end
        if (we_i[1]) begin
            mem_q[waddr1_i] <= wdata1_i;
        end
    end

    assign rdata0_o = mem_q[raddr0_i];
    assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/decode_inst_queue.sv
// Dual-issue fetch-to-decode instruction queue with pointer/count control.
// Optional same-cycle bypass of incoming entries when defined: IQ_BYPASS_EN.
module decode_inst_queue
    import decode_inst_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [1:0]       in_valid,
    input  logic [1:0][31:0] in_pc,
    input  logic [1:0][31:0] in_inst,
    input  logic [1:0]       in_exc,
    input  logic [1:0][6:0]  in_exc_cause,
    output logic             in_ready,
    output logic [1:0]       out_valid,
    output logic [1:0][31:0] out_pc,
    output logic [1:0][31:0] out_inst,
    output logic [1:0]       out_exc,
    output logic [1:0][6:0]  out_exc_cause,
    input  logic [1:0]       dec_accept
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    fetch_entry_t [1:0] in_ent_s, rd_ent_s, out_ent_s;
    fetch_entry_t       wr_ent0_s;
    logic [1:0] in_vld_s, st_vld_s, out_vld_s, acc_s, we_s;
    logic [1:0] push_n_s, pop_n_s, st_avail_s, pop_st_s, pop_in_s, wr_n_s;
    logic       push_ok_s;

    assign in_ready  = (count_q <= READY_MAX);
    assign push_ok_s = in_ready && !flush;
    assign in_vld_s  = in_valid[0] ? in_valid : 2'b00;
    assign push_n_s  = push_ok_s ? popcnt2(in_vld_s) : 2'd0;
    assign st_vld_s  = {count_q >= CW'(2), count_q >= CW'(1)};

    // pack incoming slots into entries
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            in_ent_s[i].pc        = in_pc[i];
            in_ent_s[i].inst      = in_inst[i];
            in_ent_s[i].exc       = in_exc[i];
            in_ent_s[i].exc_cause = in_exc_cause[i];
        end
    end

    // decoder-facing view: stored entries, optionally topped up from the input
    always_comb begin
        out_ent_s = rd_ent_s;
        out_vld_s = st_vld_s;
`ifdef IQ_BYPASS_EN
        if (push_ok_s && (count_q == CW'(0))) begin
            out_ent_s = in_ent_s;
            out_vld_s = in_vld_s;
        end else if (push_ok_s && (count_q == CW'(1)) && in_vld_s[0]) begin
            out_ent_s[1] = in_ent_s[0];
            out_vld_s[1] = 1'b1;
        end else begin
            out_vld_s = st_vld_s;
        end
`endif
    end

    // drive decoder outputs, zeroed where the slot is empty
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            out_pc[i]        = out_vld_s[i] ? out_ent_s[i].pc        : 32'd0;
            out_inst[i]      = out_vld_s[i] ? out_ent_s[i].inst      : 32'd0;
            out_exc[i]       = out_vld_s[i] ? out_ent_s[i].exc       : 1'b0;
            out_exc_cause[i] = out_vld_s[i] ? out_ent_s[i].exc_cause : 7'd0;
        end
        out_valid = out_vld_s;
    end

    // Pops consume stored entries first; any remainder came straight off the
    // input and is therefore never written.
    assign acc_s      = dec_accept[0] ? dec_accept : 2'b00;
    assign pop_n_s    = popcnt2(acc_s & out_vld_s);
    assign st_avail_s = (count_q >= CW'(2)) ? 2'd2 : count_q[1:0];
    assign pop_st_s   = (pop_n_s > st_avail_s) ? st_avail_s : pop_n_s;
    assign pop_in_s   = pop_n_s - pop_st_s;
    assign wr_n_s     = push_n_s - pop_in_s;
    assign we_s       = {wr_n_s == 2'd2, wr_n_s != 2'd0};
    assign wr_ent0_s  = pop_in_s[0] ? in_ent_s[1] : in_ent_s[0];

    // pointer and count next state, flush has priority
    always_comb begin
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PW'(pop_st_s);
            tail_d  = tail_q + PW'(wr_n_s);
            count_d = count_q + CW'(push_n_s) - CW'(pop_n_s);
        end
    end

    // control state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    iq_storage #(.DEPTH(DEPTH)) u_storage (
        .clk      (clk),
        .we_i     (we_s),
        .waddr0_i (tail_q),
        .waddr1_i (tail_q + PW'(1)),
        .wdata0_i (wr_ent0_s),
        .wdata1_i (in_ent_s[1]),
        .raddr0_i (head_q),
        .raddr1_i (head_q + PW'(1)),
        .rdata0_o (rd_ent_s[0]),
        .rdata1_o (rd_ent_s[1])
    );

endmodule

// File: tb/tb_decode_inst_queue.sv
// Scoreboard bench for decode_inst_queue: a reference queue of expected entries
// is fed on push and drained/compared as the decoder slots present them.
module tb_decode_inst_queue;
    import decode_inst_queue_pkg::*;

    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             rst, flush;
    logic [1:0]       in_valid, out_valid, dec_accept;
    logic [1:0][31:0] in_pc, in_inst, out_pc, out_inst;
    logic [1:0]       in_exc, out_exc;
    logic [1:0][6:0]  in_exc_cause, out_exc_cause;
    logic             in_ready;

    fetch_entry_t exp_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    logic [31:0]  pc_ctr   = 32'h1c000000;
    logic         fix_inst = 1'b0;

    always #5 clk = ~clk;

    decode_inst_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
        .in_exc(in_exc), .in_exc_cause(in_exc_cause), .in_ready(in_ready),
        .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
        .out_exc(out_exc), .out_exc_cause(out_exc_cause), .dec_accept(dec_accept)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid = 2'b00; dec_accept = 2'b00; flush = 1'b0;
        in_pc = '0; in_inst = '0; in_exc = '0; in_exc_cause = '0;
    endtask

    // One clock cycle: drive, compare decoder view with scoreboard, update scoreboard.
    task automatic cyc(input logic [1:0] v, input logic [1:0] acc, input logic fl);
        fetch_entry_t inc [2];
        fetch_entry_t vis [$];
        fetch_entry_t nxt [$];
        logic         push_ok, rdy;
        logic [1:0]   a, ev;
        int           n;
        for (int i = 0; i < 2; i++) begin
            inc[i].pc        = pc_ctr + 32'(4 * i);
            inc[i].inst      = (fix_inst && i == 0) ? 32'h02800421 : $urandom;
            inc[i].exc       = ($urandom_range(0, 3) == 0);
            inc[i].exc_cause = inc[i].exc ? 7'($urandom_range(1, 15)) : 7'd0;
            in_pc[i]         = inc[i].pc;
            in_inst[i]       = inc[i].inst;
            in_exc[i]        = inc[i].exc;
            in_exc_cause[i]  = inc[i].exc_cause;
        end
        in_valid = v; dec_accept = acc; flush = fl;
        @(negedge clk);
        rdy     = (exp_q.size() <= DEPTH - 2);
        push_ok = rdy && !fl;
        check_val("in_ready", 64'(in_ready), 64'(rdy));
        vis = exp_q;
`ifdef IQ_BYPASS_EN
        if (push_ok && exp_q.size() < 2) begin
            for (int i = 0; i < 2; i++) if (v[i]) vis.push_back(inc[i]);
        end
`endif
        for (int s = 0; s < 2; s++) begin
            ev[s] = (vis.size() > s);
            check_val($sformatf("out_valid[%0d]", s), 64'(out_valid[s]), 64'(ev[s]));
            check_val($sformatf("out_pc[%0d]", s), 64'(out_pc[s]), ev[s] ? 64'(vis[s].pc) : 64'd0);
            check_val($sformatf("out_inst[%0d]", s), 64'(out_inst[s]), ev[s] ? 64'(vis[s].inst) : 64'd0);
            check_val($sformatf("out_exc[%0d]", s), {out_exc[s], out_exc_cause[s]},
                      ev[s] ? {vis[s].exc, vis[s].exc_cause} : 64'd0);
        end
        a = acc[0] ? acc : 2'b00;
        n = $countones(a & ev);
        if (fl) begin
            exp_q.delete();
        end else begin
            nxt = exp_q;
            if (push_ok) for (int i = 0; i < 2; i++) if (v[i]) nxt.push_back(inc[i]);
            for (int k = 0; k < n; k++) void'(nxt.pop_front());
            exp_q = nxt;
        end
        if (push_ok) pc_ctr = pc_ctr + 32'(4 * $countones(v));
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    initial begin
        logic [1:0] rv, ra;
        idle_inputs();
        rst = 1'b1;
        #1;
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_in_ready", 64'(in_ready), 64'd1);
        check_val("rst_out_pc0", 64'(out_pc[0]), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // push two, no accept, then look at both slots
        cyc(2'b11, 2'b00, 1'b0);
        @(negedge clk);
        check_val("t1_valid", 64'(out_valid), 64'(2'b11));
        check_val("t1_pc0", 64'(out_pc[0]), 64'h1c000000);
        check_val("t1_pc1", 64'(out_pc[1]), 64'h1c000004);
        @(posedge clk); #1;

        // fill, then a dropped push while full
        for (int i = 0; i < 4; i++) cyc(2'b11, 2'b00, 1'b0);
        check_val("t2_full_count", 64'(exp_q.size()), 64'd8);
        cyc(2'b11, 2'b00, 1'b0);
        for (int i = 0; i < 3; i++) cyc(2'b00, 2'b11, 1'b0);

        // steady state across pointer wrap
        for (int i = 0; i < 20; i++) cyc(2'b11, 2'b11, 1'b0);

        // count=3, accept one, push two
        for (int i = 0; i < 2; i++) cyc(2'b00, 2'b11, 1'b0);
        cyc(2'b11, 2'b00, 1'b0);
        cyc(2'b01, 2'b00, 1'b0);
        check_val("t4_pre_count", 64'(exp_q.size()), 64'd3);
        cyc(2'b11, 2'b01, 1'b0);
        cyc(2'b00, 2'b00, 1'b0);

        // flush at count=5 beats push and accept
        cyc(2'b01, 2'b10, 1'b0);
        check_val("t5_pre_count", 64'(exp_q.size()), 64'd5);
        cyc(2'b11, 2'b11, 1'b1);
        @(negedge clk);
        check_val("t5_valid", 64'(out_valid), 64'd0);
        check_val("t5_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

`ifdef IQ_BYPASS_EN
        fix_inst = 1'b1;
        in_valid = 2'b01; dec_accept = 2'b01;
        in_inst[0] = 32'h02800421;
        #1;
        check_val("t6_bypass_inst", 64'(out_inst[0]), 64'h02800421);
        idle_inputs();
        cyc(2'b01, 2'b01, 1'b0);
        fix_inst = 1'b0;
        check_val("t6_count", 64'(exp_q.size()), 64'd0);
`endif

        // random traffic
        for (int i = 0; i < 300; i++) begin
            rv = 2'($urandom_range(0, 2));
            rv = (rv == 2'd2) ? 2'b11 : rv;
            ra = 2'($urandom_range(0, 3));
            cyc(rv, ra, ($urandom_range(0, 39) == 0));
        end

        // asynchronous reset mid-cycle
        cyc(2'b11, 2'b00, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_val("async_rst_valid", 64'(out_valid), 64'd0);
        check_val("async_rst_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        cyc(2'b00, 2'b11, 1'b0);
        cyc(2'b11, 2'b00, 1'b0);
        cyc(2'b00, 2'b00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
